alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU (3-bit alucontrol: AND, OR, ADD, SUB, SLT) between two requesters. Each requester uses valid/ready request and response channels. The block drives the shared ALU's operand and control inputs combinationally from the granted request, then registers the ALU result and zero flag. It holds that response for its owner until the owner accepts it.

## Interface
- WIDTH, 8, operand/result width
- CTRL_W, 3, ALU control width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  CTRL_W  alucontrol value, passed to the ALU unchanged
- rsp0_valid / rsp1_valid  out  1  response held for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes the response
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_ctrl  out  CTRL_W  to shared ALU
- alu_result  in  WIDTH  from shared ALU (combinational)
- alu_zero  in  1  from shared ALU
- gnt0_cnt, gnt1_cnt  out  8  grant counters (present only with ALU_ARB_CNT_EN)

## Operation
- **States.**
  - IDLE: no response pending.
  - HOLD: one response is registered; `owner` records which requester.
- **Issue slot.** The slot is open in IDLE. It is also open in HOLD in any cycle where the owner's rsp_ready is 1 (drain and issue in the same cycle).
- **Arbitration in an open slot.**
  - If exactly one reqN_valid is 1, that requester is granted.
  - If both are 1, the requester not granted last wins.
  - `last` resets to 1, so req0 wins the first tie.
- **Grant outputs.**
  - Only the granted requester sees reqN_ready=1.
  - reqN_ready is combinational from reqN_valid, state and the owner's rsp_ready.
- **ALU drive.**
  - On grant, alu_a, alu_b and alu_ctrl equal the granted request's fields in the same cycle.
  - With no grant, they are all 0 (AND 0,0).
- **Capture on grant edge.**
  - The response register loads alu_result and alu_zero.
  - owner and last are set to the granted requester.
  - The next state is HOLD.
- **Drain without new grant.** If the owner's rsp_ready is 1 and there is no grant, the next state is IDLE.
- **Response outputs.**
  - rspN_valid = (state==HOLD && owner==N).
  - rspN_result and rspN_zero show the register when valid and 0 otherwise.
  - The non-owner's rsp_ready is ignored.
- **op pass-through.** The op field is not decoded. Values 3'b011, 3'b100, 3'b101 pass through unchanged.

## Timing
- **Reset values.** All outputs are 0 while reset_n is low. State is IDLE and last=1.
- **Reset release.** Arbitration starts in the first cycle after release.
- **Latency.** Request accepted in cycle T gives rsp valid in cycle T+1.
- **Throughput.** One operation per cycle when the owner holds rsp_ready=1 continuously.
- **Backpressure.** While in HOLD with the owner's rsp_ready=0:
  - the response stays stable;
  - both req_ready are 0;
  - the ALU drive is 0.
- **Combinational paths.** reqN_valid → reqN_ready, and rsp_ready → req_ready. Both are documented and allowed.
- **Reset mid-HOLD.** The pending response is discarded without handshake.

## Configuration
- **ALU_ARB_CNT_EN defined.**
  - Adds gnt0_cnt and gnt1_cnt.
  - Each counter increments on every grant to its requester and saturates at 8'hFF.
  - Both reset to 0.
- **ALU_ARB_CNT_EN undefined.** The ports and counters are absent. Arbitration behaviour is identical.

## Structure
- **alu_arb_pkg** holds:
  - the state enum (IDLE, HOLD);
  - alucontrol localparams: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111;
  - the CNT_MAX constant.
- **rr_pick2** is a sub-module: a 2-way round-robin picker.
  - Inputs: valid[1:0], last, enable.
  - Outputs: one-hot gnt[1:0].
  - It is purely combinational.
- **Shared ALU.** It is instantiated outside this block and connected through the alu_* ports.

## Test plan
- **Single ADD.**
  - Stimulus: req0 sends op=010, a=8'h05, b=8'h03, rsp0_ready=1.
  - Response: req0_ready=1 in cycle T; rsp0_valid=1, result=8'h08, zero=0 in cycle T+1.
- **Tie after reset.**
  - Stimulus: req0 and req1 valid continuously, both rsp_ready=1.
  - Response: grants alternate 0, 1, 0, 1, one per cycle.
- **Backpressure.**
  - Stimulus: req1 SUB 8'h09−8'h04, then rsp1_ready=0 for 3 cycles while req0 is valid.
  - Response: rsp1 holds 8'h05 for 3 cycles; req0_ready=0; alu_ctrl=000.
  - Then rsp1_ready=1: req0 is granted in that same cycle.
- **Zero and SLT.**
  - SUB 8'h2A−8'h2A gives result 8'h00 with zero=1.
  - SLT a=8'h01, b=8'h02 gives result 8'h01 with zero=0.
- **Reset mid-HOLD.**
  - Stimulus: assert reset_n=0 while rsp0_valid=1.
  - Response: rsp0_valid drops immediately.
  - After release, a tie is granted to req0.
- **Counter saturation (ALU_ARB_CNT_EN).**
  - Stimulus: 300 req0 grants.
  - Response: gnt0_cnt=8'hFF, gnt1_cnt=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// The optional grant counters (macro ALU_ARB_CNT_EN) use CNT_MAX as their ceiling.
package alu_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// On a tie the requester that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    // One-hot grant: a single requester wins outright, a tie goes away from 'last'
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = valid;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two valid/ready requesters.
// Drives the ALU combinationally from the granted request, registers the result
// and holds it for the owner until it is taken. Defining ALU_ARB_CNT_EN adds
// saturating per-requester grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
`ifdef ALU_ARB_CNT_EN
    ,
    output logic [7:0]        gnt0_cnt,
    output logic [7:0]        gnt1_cnt
`endif
);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             owner_rsp_ready;
    logic             slot_open;
    logic [1:0]       gnt;

    // The owner's rsp_ready lets a new request issue in the same cycle the old response drains.
    // Reset gates the slot so nothing is granted while reset_n is low.
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    assign slot_open       = reset_n && ((state_q == IDLE) || owner_rsp_ready);

    rr_pick2 u_pick (
        .valid  ({req1_valid, req0_valid}),
        .last   (last_q),
        .enable (slot_open),
        .gnt    (gnt)
    );

    // State and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Next state: a grant captures the ALU output, a drain with no grant returns to IDLE
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (gnt != 2'b00) begin
            state_d  = HOLD;
            owner_d  = gnt[1];
            last_d   = gnt[1];
            result_d = alu_result;
            zero_d   = alu_zero;
        end else if ((state_q == HOLD) && owner_rsp_ready) begin
            state_d = IDLE;
        end
    end

    // Outputs: grant handshake, ALU drive from the granted request, masked responses
    always_comb begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = CTRL_W'(ALU_AND);
        if (gnt[0]) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
        end else if (gnt[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
        rsp0_valid  = (state_q == HOLD) && !owner_q;
        rsp1_valid  = (state_q == HOLD) && owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp0_zero   = rsp0_valid && zero_q;
        rsp1_zero   = rsp1_valid && zero_q;
    end

`ifdef ALU_ARB_CNT_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    // Grant counters stick at CNT_MAX rather than wrapping
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt[0] && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + 8'd1;
        if (gnt[1] && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 8'd1;
    end

    // Grant counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt0_cnt = cnt0_q;
    assign gnt1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The bench models the shared ALU and keeps
// a reference model of arbitration plus a scoreboard of expected responses.
module tb_alu_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_result, rsp1_result;
    logic       rsp0_zero, rsp1_zero;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_ctrl;
    logic       alu_zero;
`ifdef ALU_ARB_CNT_EN
    logic [7:0] gnt0_cnt, gnt1_cnt;
`endif

    typedef struct packed {
        logic       owner;
        logic [7:0] result;
        logic       zero;
    } sb_t;

    sb_t sbQueue[$];

    int checks = 0;
    int errors = 0;

    // Reference model state for arbitration
    logic modelHold;
    logic modelOwner;
    logic modelLast;

    alu_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
`ifdef ALU_ARB_CNT_EN
        ,
        .gnt0_cnt    (gnt0_cnt),
        .gnt1_cnt    (gnt1_cnt)
`endif
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 8-bit ALU used both as the external ALU and as the expected-value source
    function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return a ^ b;
        endcase
    endfunction

    // The shared ALU sits outside the DUT and answers combinationally
    assign alu_result = aluRef(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 8'h00);

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, check responses and grants, and advance the model
    task automatic applyStimulus(
        input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
        input logic r0, input logic r1);
        logic       open;
        logic       ownerReady;
        logic [1:0] expGnt;
        sb_t        head;
        sb_t        entry;
        logic [18:0] expDrive;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        if (modelHold) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_empty", 32'd1, 32'd0);
                head = '0;
            end else begin
                head = sbQueue[0];
            end
            checkOutput("rsp_valid", {rsp1_valid, rsp0_valid}, head.owner ? 2'b10 : 2'b01);
            checkOutput("rsp_result", {rsp1_result, rsp0_result},
                        head.owner ? {head.result, 8'h00} : {8'h00, head.result});
            checkOutput("rsp_zero", {rsp1_zero, rsp0_zero},
                        head.owner ? {head.zero, 1'b0} : {1'b0, head.zero});
        end else begin
            checkOutput("rsp_idle", {rsp1_valid, rsp0_valid, rsp1_result, rsp0_result}, 18'h0);
        end
        ownerReady = modelOwner ? r1 : r0;
        open = !modelHold || ownerReady;
        expGnt = 2'b00;
        if (open) begin
            if (v0 && v1) expGnt = modelLast ? 2'b01 : 2'b10;
            else          expGnt = {v1, v0};
        end
        checkOutput("req_ready", {req1_ready, req0_ready}, expGnt);
        if (expGnt[0])      expDrive = {a0, b0, op0};
        else if (expGnt[1]) expDrive = {a1, b1, op1};
        else                expDrive = '0;
        checkOutput("alu_drive", {alu_a, alu_b, alu_ctrl}, expDrive);
        if (modelHold && ownerReady && sbQueue.size() != 0) void'(sbQueue.pop_front());
        if (expGnt != 2'b00) begin
            entry.owner  = expGnt[1];
            entry.result = expGnt[0] ? aluRef(op0, a0, b0) : aluRef(op1, a1, b1);
            entry.zero   = (entry.result == 8'h00);
            sbQueue.push_back(entry);
            modelHold  = 1'b1;
            modelOwner = expGnt[1];
            modelLast  = expGnt[1];
        end else if (modelHold && ownerReady) begin
            modelHold = 1'b0;
        end
    endtask

    // Idle cycle with both requesters ready to drain
    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
    endtask

    // Assert reset with both requests pending, check every output is quiet, then release
    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'b010;
        req1_a = 8'h33; req1_b = 8'h44; req1_op = 3'b001;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        checkOutput("reset_rsp", {rsp1_valid, rsp0_valid, rsp1_result, rsp0_result, rsp1_zero, rsp0_zero}, 20'h0);
        checkOutput("reset_req", {req1_ready, req0_ready}, 2'b00);
        checkOutput("reset_alu", {alu_a, alu_b, alu_ctrl}, 19'h0);
`ifdef ALU_ARB_CNT_EN
        checkOutput("reset_cnt", {gnt1_cnt, gnt0_cnt}, 16'h0);
`endif
        sbQueue.delete();
        modelHold = 1'b0; modelOwner = 1'b0; modelLast = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Main sequence
    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        modelHold = 1'b0; modelOwner = 1'b0; modelLast = 1'b1;
        doReset();

        $display("[TB] tie after reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 8'h10, 3'b010, 1'b1, 8'h0F, 8'(i), 3'b001, 1'b1, 1'b1);
        end
        idleCycle();
        idleCycle();

        $display("[TB] single add");
        applyStimulus(1'b1, 8'h05, 8'h03, 3'b010, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        idleCycle();

        $display("[TB] backpressure");
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h09, 8'h04, 3'b110, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hF0, 8'h0F, 3'b001, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 8'hF0, 8'h0F, 3'b001, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        idleCycle();

        $display("[TB] zero, slt and op pass-through");
        applyStimulus(1'b1, 8'h2A, 8'h2A, 3'b110, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h01, 8'h02, 3'b111, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h5A, 8'h0F, 3'b011, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h77, 8'h77, 3'b100, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hC3, 8'h3C, 3'b101, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        idleCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idleCycle();
        idleCycle();

        $display("[TB] reset mid-hold");
        applyStimulus(1'b1, 8'h12, 8'h34, 3'b010, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
        doReset();
        applyStimulus(1'b1, 8'h01, 8'h01, 3'b010, 1'b1, 8'h02, 8'h02, 3'b010, 1'b1, 1'b1);
        idleCycle();

`ifdef ALU_ARB_CNT_EN
        $display("[TB] counter saturation");
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 8'(i), 8'h01, 3'b010, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 1'b1);
        end
        idleCycle();
        checkOutput("gnt0_cnt", gnt0_cnt, 8'hFF);
        checkOutput("gnt1_cnt", gnt1_cnt, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
